// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter: a small FIFO feeding a start/data/parity/stop serialiser.
// Data bits go out LSB first; every bit lasts CLK_FREQ/BR clocks.
module uart_tx_cfg #(
  parameter int unsigned B_PER_T    = 8,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BR         = 9600,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          RST,
  input  logic [B_PER_T-1:0]            i_data,
  input  logic                          DV,
  output logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BR;
  localparam int unsigned STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int unsigned BAUD_W   = $clog2(STOP_LEN);
  localparam int unsigned BIT_W    = $clog2(B_PER_T);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  generate
    if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_cfg: CLK_FREQ/BR must be at least 2");
    end
    if (B_PER_T < 5 || B_PER_T > 9) begin : g_bad_width
      $error("uart_tx_cfg: B_PER_T must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Word FIFO; pointers wrap naturally because the depth is a power of two.
  logic [B_PER_T-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               wr_en, pop;

  assign o_ready    = count < CNT_W'(FIFO_DEPTH);
  assign wr_en      = DV && o_ready;
  assign o_fifo_cnt = count;

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Serialiser state
  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [B_PER_T-1:0] shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge i_clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx/busy/done are computed one cycle ahead so the line is driven straight from flops.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (count != '0) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr];
          par_d   = (^mem[rd_ptr]) ^ (PARITY == 2);
          baud_d  = BAUD_W'(BAUD_DIV - 1);
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_W'(BAUD_DIV - 1);
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_W'(BAUD_DIV - 1);
          if (bit_q == BIT_W'(B_PER_T - 1)) begin
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              baud_d  = BAUD_W'(STOP_LEN - 1);
              state_d = S_STOP;
            end
          end else begin
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            bit_d   = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_q == '0) begin
          tx_d    = 1'b1;
          baud_d  = BAUD_W'(STOP_LEN - 1);
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_STOP: begin
        done_d = (baud_q == BAUD_W'(1));
        if (baud_q == '0) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 9N2) at BAUD_DIV = 10,
// frames captured cycle by cycle and compared with a bit-list model of the frame.
module tb_uart_tx_cfg;

  localparam int BD = 10;

  typedef logic [8:0] wq_t[$];

  logic       clk;
  logic       rst;
  logic [8:0] data [4];
  logic [3:0] dv;
  wire  [3:0] ready, txv, busy, done;
  wire  [2:0] cnt [4];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned NBG = (g == 3) ? 9 : 8;
    localparam int unsigned PG  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
    localparam int unsigned SG  = (g == 3) ? 2 : 1;
    uart_tx_cfg #(
      .B_PER_T(NBG), .CLK_FREQ(1_000_000), .BR(100_000),
      .PARITY(PG), .STOP_BITS(SG), .FIFO_DEPTH(4)
    ) u_dut (
      .i_clk(clk), .RST(rst), .i_data(data[g][NBG-1:0]), .DV(dv[g]),
      .o_ready(ready[g]), .o_fifo_cnt(cnt[g]), .tx(txv[g]),
      .tx_busy(busy[g]), .tx_done(done[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  function automatic int nb_of(input int i);
    return (i == 3) ? 9 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
  endfunction
  function automatic int stop_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int flen(input int i);
    return (1 + nb_of(i) + ((par_of(i) != 0) ? 1 : 0) + stop_of(i)) * BD;
  endfunction
  function automatic logic [127:0] ones(input int f);
    return {128{1'b1}} >> (128 - f);
  endfunction

  // Expected line level per clock, built from the ordered list of frame bits.
  function automatic logic [127:0] exp_tx(input int idx, input logic [8:0] w);
    int bits[$];
    logic p;
    logic [127:0] e;
    p = 1'b0;
    bits.push_back(0);
    for (int i = 0; i < nb_of(idx); i++) begin
      bits.push_back(w[i] ? 1 : 0);
      p ^= w[i];
    end
    if (par_of(idx) != 0) bits.push_back((p ^ (par_of(idx) == 2)) ? 1 : 0);
    for (int s = 0; s < stop_of(idx); s++) bits.push_back(1);
    e = '0;
    for (int k = 0; k < bits.size() * BD; k++) e[k] = (bits[k / BD] != 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a start bit, then record one full frame plus the following idle cycle.
  task automatic capture(input int idx, input logic [8:0] w, input int max_wait,
                         output int waited, output logic [127:0] ot);
    int f;
    logic [127:0] ob, od;
    f = flen(idx);
    waited = 0;
    while (txv[idx] !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    ot = '0; ob = '0; od = '0;
    for (int k = 0; k < f; k++) begin
      ot[k] = txv[idx];
      ob[k] = busy[idx];
      od[k] = done[idx];
      @(negedge clk);
    end
    chk($sformatf("tx%0d_%0h", idx, w), ot, exp_tx(idx, w));
    chk($sformatf("busy%0d_%0h", idx, w), ob, ones(f));
    chk($sformatf("done%0d_%0h", idx, w), od, 128'(1) << (f - 1));
    chk($sformatf("after%0d_%0h", idx, w), 128'({txv[idx], busy[idx], done[idx]}), 128'(3'b100));
  endtask

  task automatic expect_frames(input int idx, input wq_t q, input int first_wait);
    int waited;
    logic [127:0] ot;
    foreach (q[j]) begin
      capture(idx, q[j], (j == 0) ? first_wait : 3, waited, ot);
      if (j > 0) chk($sformatf("gap%0d_%0d", idx, j), 128'(waited), 128'(1));
    end
  endtask

  // Producer: hold DV until ready, one word per accepting edge.
  task automatic send_words(input int idx, input wq_t q);
    int n;
    foreach (q[j]) begin
      data[idx] = q[j];
      dv[idx] = 1'b1;
      n = 0;
      while (ready[idx] !== 1'b1 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    dv[idx] = 1'b0;
  endtask

  task automatic idle_watch(input int idx, input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      if (txv[idx] !== 1'b1 || busy[idx] !== 1'b0 || done[idx] !== 1'b0) bad++;
      @(negedge clk);
    end
    chk(tag, 128'(bad), 128'(0));
  endtask

  initial begin
    wq_t q, q2;
    int waited, n;
    logic [127:0] ot, pat_v;
    logic [5:0] rdy;
    int pat [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    rst = 1'b1;
    dv = '0;
    for (int i = 0; i < 4; i++) data[i] = '0;

    // Reset state, before any clock edge
    #3;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_out%0d", i),
          128'({txv[i], busy[i], done[i], ready[i], cnt[i]}), 128'(7'b1001_000));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 single word 0xA5 from idle: latency, count and exact waveform
    data[0] = 9'h0A5;
    dv[0] = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    chk("lat_accept", 128'({txv[0], cnt[0]}), 128'(4'b1_001));
    @(negedge clk);
    chk("lat_pop", 128'({txv[0], busy[0], cnt[0]}), 128'(5'b01_000));
    capture(0, 9'h0A5, 5, waited, ot);
    chk("lat_start", 128'(waited), 128'(0));
    pat_v = '0;
    for (int k = 0; k < 100; k++) pat_v[k] = (pat[k / BD] != 0);
    chk("a5_pattern", ot, pat_v);
    idle_watch(0, 10, "a5_idle");

    // Parity: even 0x07 -> 1, odd 0x07 -> 0, even 0x00 -> 0
    q = '{9'h007, 9'h000};
    fork
      send_words(1, q);
      expect_frames(1, q, 30);
    join
    q = '{9'h007};
    fork
      send_words(2, q);
      expect_frames(2, q, 30);
    join
    q = '{9'h1FF};
    fork
      send_words(3, q);
      expect_frames(3, q, 30);
    join

    // FIFO fill: DV held 6 cycles, sixth word dropped
    q = '{9'h011, 9'h012, 9'h013, 9'h014, 9'h015};
    fork
      begin
        for (int j = 0; j < 6; j++) begin
          rdy[j] = ready[0];
          data[0] = 9'(9'h011 + j);
          dv[0] = 1'b1;
          @(negedge clk);
        end
        dv[0] = 1'b0;
        chk("fill_ready", 128'(rdy), 128'(6'b011111));
        chk("fill_cnt", 128'({ready[0], cnt[0]}), 128'(4'b0_100));
      end
      expect_frames(0, q, 30);
    join
    idle_watch(0, 30, "fill_no_sixth");

    // Randomised back-to-back traffic on every configuration
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        q = {};
        n = $urandom_range(1, 6);
        for (int j = 0; j < n; j++) q.push_back(9'($urandom) & ((i == 3) ? 9'h1FF : 9'h0FF));
        fork
          send_words(i, q);
          expect_frames(i, q, 30);
        join
        idle_watch(i, 5, $sformatf("rand_idle%0d", i));
        chk($sformatf("rand_cnt%0d", i), 128'(cnt[i]), 128'(0));
      end
    end

    // Hold-off: FIFO full, 0x3C held until a slot frees, sent exactly once
    q = {};
    for (int j = 0; j < 5; j++) q.push_back(9'($urandom) & 9'h0FF);
    q2 = q;
    q2.push_back(9'h03C);
    fork
      begin
        send_words(0, q);
        chk("hold_full", 128'({ready[0], cnt[0]}), 128'(4'b0_100));
        data[0] = 9'h03C;
        dv[0] = 1'b1;
        n = 0;
        while (ready[0] !== 1'b1 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        dv[0] = 1'b0;
        chk("hold_cnt", 128'(cnt[0]), 128'(4));
      end
      expect_frames(0, q2, 30);
    join
    idle_watch(0, 30, "hold_once");

    // Reset during data bit 3 with two words queued
    q = '{9'h0C9, 9'h033, 9'h0F0};
    send_words(0, q);
    repeat (40) @(negedge clk);
    chk("pre_rst", 128'({txv[0], busy[0], cnt[0]}), 128'({1'b1, 1'b1, 3'd2}));
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 128'({txv[0], busy[0], done[0], ready[0], cnt[0]}), 128'(7'b1001_000));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_watch(0, 40, "post_rst_idle");
    q = '{9'h05A};
    fork
      send_words(0, q);
      expect_frames(0, q, 30);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
